// File: rtl/interrupt_sequencer_pkg.sv
// interrupt_sequencer_pkg: shared FSM encodings and injected opcodes (cpu_ctrl_defs)
package interrupt_sequencer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_IMM, S_BUBBLE, S_PUSH1, S_PUSH2, S_VECTOR} state_t;
  localparam logic [15:0] BUBBLE_INSTR = 16'h07F8;
  localparam logic [15:0] INT_PART1 = 16'hF480;
  localparam logic [15:0] INT_PART2 = 16'hF500;
  localparam logic [2:0] FUNC_IMM = 3'b100;
endpackage

// File: rtl/interrupt_sequencer_int_req_latch.sv
// int_req_latch: rising-edge detect on int_req with a one-deep pending flag
module int_req_latch (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_set_en,
  input  logic i_clr,
  output logic o_pending
);
  logic r_req_d;
  logic r_pending;
  logic w_edge;
  assign w_edge = i_req & ~r_req_d;
  assign o_pending = r_pending;
  // a fresh edge beats a same-cycle clear so that request is never lost
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_req_d <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_req_d <= i_req;
      r_pending <= (w_edge && i_set_en) ? 1'b1 : i_clr ? 1'b0 : r_pending;
    end
endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: interrupt entry sequencing for decode injection and fetch control; INT_PENDING_QUEUE_EN queues edges seen while busy
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int NUM_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        fetch_is_imm,
  input  logic        load_use_stall,
  input  logic        branch_taken,
  output logic        inject_valid,
  output logic [15:0] inject_instr,
  output logic        stall_fetch,
  output logic        int_to_fetch,
  output logic        int_busy
);
  localparam logic [1:0] CNT_INIT = 2'(NUM_BUBBLES - 1);
  state_t     r_state;
  state_t     w_state_nx;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nx;
  logic       w_pending;
  logic       w_clr;
  logic       w_set_en;
  logic       w_inj;
`ifdef INT_PENDING_QUEUE_EN
  assign w_set_en = 1'b1;
`else
  assign w_set_en = (r_state == S_IDLE);
`endif
  int_req_latch u_latch (
    .clk      (clk),
    .rst      (rst),
    .i_req    (int_req),
    .i_set_en (w_set_en),
    .i_clr    (w_clr),
    .o_pending(w_pending)
  );
  // state and bubble counter registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
    end
  // next state: a taken branch flushes injected ops and restarts from the bubbles
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt;
    w_clr = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_pending && !load_use_stall) begin
          w_clr = 1'b1;
          w_state_nx = fetch_is_imm ? S_WAIT_IMM : S_BUBBLE;
          w_cnt_nx = CNT_INIT;
        end
      S_WAIT_IMM: begin
        w_state_nx = S_BUBBLE;
        w_cnt_nx = CNT_INIT;
      end
      S_BUBBLE:
        if (branch_taken) w_cnt_nx = CNT_INIT;
        else if (!load_use_stall) begin
          w_state_nx = (r_cnt == 2'd0) ? S_PUSH1 : S_BUBBLE;
          w_cnt_nx = (r_cnt == 2'd0) ? r_cnt : r_cnt - 2'd1;
        end
      S_PUSH1, S_PUSH2:
        if (branch_taken) begin
          w_state_nx = S_BUBBLE;
          w_cnt_nx = CNT_INIT;
        end else if (!load_use_stall) w_state_nx = (r_state == S_PUSH1) ? S_PUSH2 : S_VECTOR;
      default: w_state_nx = S_IDLE;
    endcase
  end
  assign w_inj = (r_state == S_BUBBLE) || (r_state == S_PUSH1) || (r_state == S_PUSH2);
  assign inject_valid = w_inj;
  assign stall_fetch = w_inj;
  assign inject_instr = (r_state == S_BUBBLE) ? BUBBLE_INSTR :
                        (r_state == S_PUSH1)  ? INT_PART1 :
                        (r_state == S_PUSH2)  ? INT_PART2 : 16'h0000;
  assign int_to_fetch = (r_state == S_VECTOR);
  assign int_busy = (r_state != S_IDLE);
endmodule
